// File: rtl/mul_pkg.sv
// Shared constants and state type for the sequential shift-add multiplier.
package mul_pkg;

  localparam int WIDTH = 6;
  localparam int NSTEP = 6;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/cla_6bit.sv
// 6-bit carry-lookahead adder; every carry is a flat sum of generate/propagate products.
module cla_6bit (
  input  logic [5:0] A,
  input  logic [5:0] B,
  input  logic       Cin,
  output logic [5:0] S
);

  logic [5:0] g;
  logic [5:0] p;
  logic [5:0] c;

  assign g    = A & B;
  assign p    = A ^ B;
  assign c[0] = Cin;

  // c[gi] = g[gi-1] | p[gi-1]g[gi-2] | ... | p[gi-1..0]Cin, with no ripple chain
  generate
    for (genvar gi = 1; gi < 6; gi++) begin : g_carry
      logic carry_bit;
      logic prop_run;
      always_comb begin
        carry_bit = g[gi-1];
        prop_run  = p[gi-1];
        for (int j = gi - 2; j >= 0; j--) begin
          carry_bit = carry_bit | (prop_run & g[j]);
          prop_run  = prop_run & p[j];
        end
        carry_bit = carry_bit | (prop_run & Cin);
      end
      assign c[gi] = carry_bit;
    end
  endgenerate

  assign S = p ^ c;

endmodule

// File: rtl/mul_seq_6bit.sv
// Unsigned 6x6 -> 12-bit shift-add multiplier: six steps through cla_6bit, start/busy/done handshake.
module mul_seq_6bit #(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  import mul_pkg::*;

  mul_state_e         state_reg;
  mul_state_e         state_next;
  logic [WIDTH-1:0]   m_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [WIDTH-1:0]   acc_reg;
  logic [2:0]         cnt_reg;
  logic [2*WIDTH-1:0] p_reg;

  logic [WIDTH-1:0]   mx;
  logic [WIDTH-1:0]   sum;
  logic               co;
  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   q_next;
  logic               last_step;

  cla_6bit u_cla (
    .A   (acc_reg),
    .B   (mx),
    .Cin (1'b0),
    .S   (sum)
  );

  always_comb begin
    mx        = q_reg[0] ? m_reg : '0;
    // The adder has no carry-out, so recover it from the two MSBs and the sum MSB
    co        = (acc_reg[WIDTH-1] & mx[WIDTH-1]) |
                ((acc_reg[WIDTH-1] | mx[WIDTH-1]) & ~sum[WIDTH-1]);
    acc_next  = {co, sum[WIDTH-1:1]};
    q_next    = {sum[0], q_reg[WIDTH-1:1]};
    last_step = (cnt_reg == 3'(NSTEP - 1));

    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      m_reg     <= '0;
      q_reg     <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      p_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            m_reg   <= A;
            q_reg   <= B;
            acc_reg <= '0;
            cnt_reg <= '0;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + 3'd1;
          if (last_step) p_reg <= {acc_next, q_next};
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign P    = p_reg;

endmodule

// File: tb/tb_mul_seq_6bit.sv
// Self-checking bench for mul_seq_6bit: directed table, random products, and handshake corner cases.
module tb_mul_seq_6bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  A;
  logic [5:0]  B;
  logic        busy;
  logic        done;
  logic [11:0] P;

  int tests;
  int fails;

  typedef struct {
    logic [5:0]  a;
    logic [5:0]  b;
    logic [11:0] p;
  } vec_t;

  vec_t vecs[6];

  mul_seq_6bit #(.WIDTH(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One product with a single-cycle start; operands are scrambled right after acceptance.
  task automatic run_op(input int a, input int b, input string tag);
    int ndone;
    int first_k;
    ndone   = 0;
    first_k = 0;
    @(negedge clk);
    start = 1'b1;
    A     = 6'(a);
    B     = 6'(b);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        A     = 6'($urandom);
        B     = 6'($urandom);
      end
      if (k == 3) check({tag, " busy_run"}, int'(busy), 1);
      if (done) begin
        ndone++;
        if (first_k == 0) begin
          first_k = k;
          check({tag, " P"}, int'(P), a * b);
          check({tag, " busy_done"}, int'(busy), 1);
        end
      end
      if (k == 8) begin
        check({tag, " busy_idle"}, int'(busy), 0);
        check({tag, " P_hold"}, int'(P), a * b);
      end
    end
    if (first_k == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s timeout: no done within 8 cycles, expected cycle 7", tag);
    end else begin
      check({tag, " latency"}, first_k, 7);
    end
    check({tag, " done_count"}, ndone, 1);
    $display("[TB] %s A=%0d B=%0d P=%0d", tag, a, b, a * b);
  endtask

  initial begin
    int ra;
    int rb;
    int ndone;
    int done_k[$];
    tests = 0;
    fails = 0;

    vecs[0] = '{a: 6'd45, b: 6'd27, p: 12'd1215};
    vecs[1] = '{a: 6'd63, b: 6'd63, p: 12'd3969};
    vecs[2] = '{a: 6'd0,  b: 6'd63, p: 12'd0};
    vecs[3] = '{a: 6'd1,  b: 6'd1,  p: 12'd1};
    vecs[4] = '{a: 6'd63, b: 6'd1,  p: 12'd63};
    vecs[5] = '{a: 6'd1,  b: 6'd63, p: 12'd63};

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset P", int'(P), 0);
    $display("[TB] reset release checked");

    foreach (vecs[i]) begin
      run_op(int'(vecs[i].a), int'(vecs[i].b), $sformatf("vec%0d", i));
      check($sformatf("vec%0d table", i), int'(P), int'(vecs[i].p));
    end

    for (int n = 0; n < 30; n++) begin
      ra = int'($urandom_range(63, 0));
      rb = int'($urandom_range(63, 0));
      run_op(ra, rb, $sformatf("rnd%0d", n));
    end

    // start re-pulsed mid-RUN with different operands must be ignored
    @(negedge clk);
    start = 1'b1; A = 6'd5; B = 6'd7;
    ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = (k == 3);
      A = (k == 3) ? 6'd60 : 6'($urandom);
      B = (k == 3) ? 6'd60 : 6'($urandom);
      if (done) begin
        ndone++;
        check("ignore P", int'(P), 35);
      end
    end
    start = 1'b0;
    check("ignore done_count", ndone, 1);
    $display("[TB] ignored-start sequence A=5 B=7 P=35");

    // reset during cycle 4 aborts silently
    @(negedge clk);
    start = 1'b1; A = 6'd45; B = 6'd27;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort P", int'(P), 0);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no_done", ndone, 0);
    $display("[TB] mid-operation reset checked");

    // back-to-back with start held high
    start = 1'b1; A = 6'd10; B = 6'd12;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 1) begin A = 6'd3; B = 6'd21; end
      if (done) begin
        done_k.push_back(k);
        if (k == 7)  check("b2b P1", int'(P), 120);
        if (k == 15) check("b2b P2", int'(P), 63);
      end
      if (k == 15) start = 1'b0;
    end
    check("b2b done_count", done_k.size(), 2);
    if (done_k.size() == 2) begin
      check("b2b done1_cycle", done_k[0], 7);
      check("b2b done2_cycle", done_k[1], 15);
    end
    $display("[TB] back-to-back 10*12 then 3*21");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
